// File: rtl/pe_driver.sv
// Sequencer for a bit-serial processing element: loads four operand words MSB first,
// runs ITERS load/compute rounds, then reads back the serial solution and residue.
module pe_driver #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ITERS = 2
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_top,
  input  logic [WIDTH-1:0] in_right,
  input  logic [WIDTH-1:0] in_down,
  output logic             pe_mode,
  output logic             pe_shift,
  output logic             pe_update,
  output logic             pe_read,
  output logic             pe_left,
  output logic             pe_top,
  output logic             pe_right,
  output logic             pe_down,
  input  logic             pe_solution,
  input  logic             pe_residue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_solution,
  output logic [WIDTH-1:0] out_residue
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [3:0] LastIter = 4'(ITERS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLupd,
    StComp,
    StCupd,
    StRead,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]      iter_q, iter_d;
  logic [WIDTH-1:0] left_q, top_q, right_q, down_q;
  logic [WIDTH-1:0] sol_q, res_q;
  logic [WIDTH-1:0] sol_shift, res_shift;
  logic [WIDTH-1:0] op_left, op_top, op_right, op_down;
  logic [CntW-1:0] bit_idx;
  logic            accept;
  logic            last_bit;

  assign accept    = (state_q == StIdle) && in_valid && in_ready;
  assign last_bit  = (bit_cnt_q == LastBit);
  assign sol_shift = {sol_q[WIDTH-2:0], pe_solution};
  assign res_shift = {res_q[WIDTH-2:0], pe_residue};

  // On the accepting edge the operand registers are still being written, so the
  // first LOAD bit comes straight from the inputs.
  assign op_left  = accept ? in_left  : left_q;
  assign op_top   = accept ? in_top   : top_q;
  assign op_right = accept ? in_right : right_q;
  assign op_down  = accept ? in_down  : down_q;
  assign bit_idx  = LastBit - bit_cnt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = '0;
    iter_d    = iter_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          iter_d  = '0;
        end
      end
      StLoad: begin
        if (last_bit) state_d = StLupd;
        else          bit_cnt_d = bit_cnt_q + CntW'(1);
      end
      StLupd: state_d = StComp;
      StComp: begin
        if (last_bit) state_d = StCupd;
        else          bit_cnt_d = bit_cnt_q + CntW'(1);
      end
      StCupd: begin
        iter_d  = iter_q + 4'd1;
        state_d = (iter_q == LastIter) ? StRead : StLoad;
      end
      StRead: begin
        if (last_bit) state_d = StDone;
        else          bit_cnt_d = bit_cnt_q + CntW'(1);
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      iter_q       <= '0;
      left_q       <= '0;
      top_q        <= '0;
      right_q      <= '0;
      down_q       <= '0;
      sol_q        <= '0;
      res_q        <= '0;
      in_ready     <= 1'b0;
      pe_mode      <= 1'b0;
      pe_shift     <= 1'b0;
      pe_update    <= 1'b0;
      pe_read      <= 1'b0;
      pe_left      <= 1'b0;
      pe_top       <= 1'b0;
      pe_right     <= 1'b0;
      pe_down      <= 1'b0;
      out_valid    <= 1'b0;
      out_solution <= '0;
      out_residue  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      iter_q    <= iter_d;
      if (accept) begin
        left_q  <= in_left;
        top_q   <= in_top;
        right_q <= in_right;
        down_q  <= in_down;
      end
      if (state_q == StRead) begin
        sol_q <= sol_shift;
        res_q <= res_shift;
      end
      in_ready  <= (state_d == StIdle);
      pe_mode   <= (state_d == StLoad) || (state_d == StLupd);
      pe_shift  <= (state_d == StLoad) || (state_d == StComp);
      pe_update <= (state_d == StLupd) || (state_d == StCupd) || (state_d == StRead);
      pe_read   <= (state_d == StRead);
      if (state_d == StLoad) begin
        pe_left  <= op_left[bit_idx];
        pe_top   <= op_top[bit_idx];
        pe_right <= op_right[bit_idx];
        pe_down  <= op_down[bit_idx];
      end else begin
        pe_left  <= 1'b0;
        pe_top   <= 1'b0;
        pe_right <= 1'b0;
        pe_down  <= 1'b0;
      end
      out_valid <= (state_d == StDone);
      if ((state_q == StRead) && (state_d == StDone)) begin
        out_solution <= sol_shift;
        out_residue  <= res_shift;
      end
    end
  end

endmodule

// File: tb/tb_pe_driver.sv
// Directed bench for pe_driver: behavioural PE read-back model, scoreboard of expected
// result words, latency / sequence / handshake / reset checks.
module tb_pe_driver;

  localparam int unsigned W  = 8;
  localparam int unsigned IT = 2;
  localparam int unsigned LAT = IT * (2 * W + 2) + W;

  logic         clka = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_left, in_top, in_right, in_down;
  logic         pe_mode, pe_shift, pe_update, pe_read;
  logic         pe_left, pe_top, pe_right, pe_down;
  logic         pe_solution, pe_residue;
  logic         out_valid, out_ready;
  logic [W-1:0] out_solution, out_residue;

  pe_driver #(.WIDTH(W), .ITERS(IT)) dut (
    .clka        (clka),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_left     (in_left),
    .in_top      (in_top),
    .in_right    (in_right),
    .in_down     (in_down),
    .pe_mode     (pe_mode),
    .pe_shift    (pe_shift),
    .pe_update   (pe_update),
    .pe_read     (pe_read),
    .pe_left     (pe_left),
    .pe_top      (pe_top),
    .pe_right    (pe_right),
    .pe_down     (pe_down),
    .pe_solution (pe_solution),
    .pe_residue  (pe_residue),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_solution(out_solution),
    .out_residue (out_residue)
  );

  always #5 clka = ~clka;

  typedef struct packed {
    logic [W-1:0] sol;
    logic [W-1:0] res;
  } exp_t;

  exp_t         sb[$];
  logic [3:0]   lane_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           cnt_shift = 0, cnt_upd = 0, cnt_lupd = 0, viol = 0;
  int           rd_idx = 0;
  logic [W-1:0] sol_bits = '0, res_bits = '0;

  always @(posedge clka) cyc <= cyc + 1;

  // PE read-back model: presents one result bit per READ cycle, MSB of the word first.
  always @(negedge clka) begin
    if (pe_read) begin
      pe_solution = sol_bits[W-1-rd_idx];
      pe_residue  = res_bits[W-1-rd_idx];
      rd_idx++;
    end else begin
      rd_idx      = 0;
      pe_solution = 1'b0;
      pe_residue  = 1'b0;
    end
  end

  always @(negedge clka) begin
    if (pe_shift) cnt_shift++;
    if (pe_update) cnt_upd++;
    if (pe_update && pe_mode) cnt_lupd++;
    if (pe_mode && pe_shift) lane_q.push_back({pe_left, pe_top, pe_right, pe_down});
    if (pe_shift && pe_update) viol++;
    if ((in_ready || out_valid) && (pe_shift || pe_update || pe_read)) viol++;
    if (in_ready && out_valid) viol++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // b2b: in_valid and out_ready are left high so commands chain through DONE->IDLE.
  task automatic do_cmd(input logic [W-1:0] l, input logic [W-1:0] t, input logic [W-1:0] r,
                        input logic [W-1:0] d, input logic [W-1:0] sol,
                        input logic [W-1:0] res, input bit hold, input bit b2b,
                        output int e0);
    int   lat;
    bit   seen;
    bit   got;
    int   unstable;
    exp_t e;
    logic [3:0] lane_exp;
    int   b;
    in_left  = l;
    in_top   = t;
    in_right = r;
    in_down  = d;
    sol_bits = sol;
    res_bits = res;
    in_valid = 1'b1;
    sb.push_back('{sol: sol, res: res});
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clka);
    end
    check("ready_wait", {31'd0, got}, 32'd1);
    @(posedge clka);
    cnt_shift = 0;
    cnt_upd   = 0;
    cnt_lupd  = 0;
    lane_q.delete();
    @(negedge clka);
    e0 = cyc;
    check("accepted", {31'd0, in_ready}, 32'd0);
    if (!b2b) in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clka);
    end
    lat = seen ? (cyc - e0) : 9999;
    check("latency", lat, LAT);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check("out_solution", out_solution, e.sol);
    check("out_residue", out_residue, e.res);
    check("shift_count", cnt_shift, 2 * W * IT);
    check("update_count", cnt_upd, 2 * IT + W);
    check("lupd_count", cnt_lupd, IT);
    check("lane_len", lane_q.size(), W * IT);
    for (int k = 0; k < lane_q.size() && k < W * IT; k++) begin
      b = W - 1 - (k % W);
      lane_exp = {l[b], t[b], r[b], d[b]};
      check($sformatf("lane[%0d]", k), lane_q[k], lane_exp);
    end
    if (!b2b) begin
      unstable = 0;
      if (hold) begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clka);
          if (!out_valid || in_ready || out_solution !== e.sol || out_residue !== e.res)
            unstable++;
        end
        check("done_hold", unstable, 0);
      end
      out_ready = 1'b1;
      @(negedge clka);
      out_ready = 1'b0;
      check("release_valid", {31'd0, out_valid}, 32'd0);
      check("release_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    int e0a, e0b;
    int ncomp;
    int stray;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_left   = '0;
    in_top    = '0;
    in_right  = '0;
    in_down   = '0;
    repeat (3) @(negedge clka);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_pe", {24'd0, pe_mode, pe_shift, pe_update, pe_read,
                     pe_left, pe_top, pe_right, pe_down}, 32'd0);
    check("rst_out", {out_valid, out_solution, out_residue}, 32'd0);
    rst = 1'b1;
    @(negedge clka);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Reference command: spec operands and PE result bits.
    do_cmd(8'hE4, 8'hE7, 8'hB0, 8'hCC, 8'hA6, 8'hFF, 1'b1, 1'b0, e0a);

    // Abort during the third COMP cycle.
    in_left  = 8'h5A;
    in_top   = 8'h3C;
    in_right = 8'h81;
    in_down  = 8'h7E;
    in_valid = 1'b1;
    sb.push_back('{sol: 8'h11, res: 8'h22});
    @(posedge clka);
    @(negedge clka);
    in_valid = 1'b0;
    ncomp = 0;
    for (int i = 0; i < 100 && ncomp < 3; i++) begin
      if (pe_shift && !pe_mode) ncomp++;
      if (ncomp < 3) @(negedge clka);
    end
    check("comp_reached", ncomp, 3);
    #2 rst = 1'b0;
    #1;
    check("async_pe", {24'd0, pe_mode, pe_shift, pe_update, pe_read,
                       pe_left, pe_top, pe_right, pe_down}, 32'd0);
    check("async_out", {out_valid, out_solution, out_residue}, 32'd0);
    check("async_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(negedge clka);
    rst = 1'b1;
    @(negedge clka);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid || pe_shift || pe_update) stray++;
      @(negedge clka);
    end
    check("abort_quiet", stray, 0);

    do_cmd(8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h3C, 8'h81, 1'b0, 1'b0, e0a);

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    do_cmd(8'h12, 8'h34, 8'h56, 8'h78, 8'hC3, 8'h00, 1'b0, 1'b1, e0a);
    do_cmd(8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h5B, 8'hE2, 1'b0, 1'b1, e0b);
    in_valid = 1'b0;
    check("b2b_gap", e0b - e0a, LAT + 2);
    @(negedge clka);
    out_ready = 1'b0;
    check("b2b_idle_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clka);
    check("invariants", viol, 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_driver.md
PE_DRIVER -- requirements
Module: pe_driver

Interface
REQ-001 Parameter WIDTH, default 8, bit-serial word width of PE operands and results.
REQ-002 Parameter ITERS, default 2, number of load/compute iterations per command (legal range 1..15).
REQ-003 clka  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1  command word present.
REQ-006 in_ready  output  1  driver accepts a command.
REQ-007 in_left, in_top, in_right, in_down  input  WIDTH each  parallel boundary/neighbour values.
REQ-008 pe_mode  output  1  PE mode: 1 = load, 0 = compute.
REQ-009 pe_shift  output  1  PE bit-clock enable (one per serial bit).
REQ-010 pe_update  output  1  PE update-clock enable.
REQ-011 pe_read  output  1  PE read-out enable.
REQ-012 pe_left, pe_top, pe_right, pe_down  output  1 each  serial operand bits to PE.
REQ-013 pe_solution, pe_residue  input  1 each  serial result bits from PE.
REQ-014 out_valid  output  1  result word available.
REQ-015 out_ready  input  1  consumer takes result.
REQ-016 out_solution, out_residue  output  WIDTH each  parallel result words.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, LUPD, COMP, CUPD, READ, DONE; all pe_* and out_* outputs SHALL be registered.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready the four inputs SHALL be captured, iteration counter cleared, state -> LOAD.
REQ-019 LOAD: WIDTH cycles; pe_mode=1, pe_shift=1; pe_left/top/right/down SHALL carry captured bits MSB first (bit WIDTH-1 on first LOAD cycle, bit 0 on last).
REQ-020 LUPD: 1 cycle; pe_update=1, pe_mode=1, pe_shift=0, operand bits 0; -> COMP.
REQ-021 COMP: WIDTH cycles; pe_mode=0, pe_shift=1, operand bits 0.
REQ-022 CUPD: 1 cycle; pe_update=1, pe_mode=0; iteration counter +1; if counter reaches ITERS -> READ, else -> LOAD reusing the same captured operands.
REQ-023 READ: WIDTH cycles; pe_read=1, pe_update=1; each cycle pe_solution and pe_residue SHALL be shifted into LSB of their result registers, so the first sampled bit ends in bit WIDTH-1.
REQ-024 DONE: out_valid=1, out_solution/out_residue stable; on out_ready -> IDLE, out_valid=0 next cycle.
REQ-025 Latency: with acceptance at edge E0, out_valid SHALL first be 1 after edge E0 + ITERS*(2*WIDTH+2) + WIDTH (44 for defaults).
REQ-026 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored.
REQ-027 A bit counter of ceil(log2(WIDTH)) bits SHALL time LOAD/COMP/READ and SHALL restart at 0 on every state entry; no wrap beyond WIDTH-1.
REQ-028 out_ready while out_valid=0 SHALL have no effect; out_ready and in_valid together in DONE: command not accepted until IDLE next cycle.
REQ-029 pe_shift, pe_update and pe_read SHALL never be 1 in IDLE or DONE; pe_shift and pe_update SHALL never be 1 together.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, all counters 0, all pe_* outputs 0, out_valid=0, out_solution=out_residue=0, in_ready=0 while asserted and 1 from the first edge after release.
REQ-031 Reset mid-operation SHALL discard captured operands and partial results; no out_valid for the aborted command.

Verification
REQ-032 Single command left=0xE4, top=0xE7, right=0xB0, down=0xCC, ITERS=2 -> pe_left sequence 1,1,1,0,0,1,0,0 in each LOAD; two LOAD+LUPD+COMP+CUPD rounds; out_valid after exactly 44 edges.
REQ-033 PE model returning solution bits 1,0,1,0,0,1,1,0 in READ -> out_solution=0xA6; residue bits all 1 -> out_residue=0xFF.
REQ-034 out_ready held 0 for 10 cycles in DONE -> out_valid and results stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 rst=0 pulsed during 3rd COMP cycle -> all outputs 0 asynchronously; new command afterwards completes with full 44-cycle latency.
REQ-036 Back-to-back commands with in_valid held 1 -> second accepted only in IDLE after DONE handshake; counts of pe_shift=2*WIDTH*ITERS, pe_update=2*ITERS+WIDTH per command.
